ram_portb_arbiter: RTL and testbench
====================================

RAM_PORTB_ARBITER -- requirements
Module: ram_portb_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 11, address width; DATA_W, 4, data width; DEPTH, 1070, valid entries; TIMEOUT, 8, max cycles waiting for ram_dob_valid.
REQ-002 Reset is asynchronous and active-high; the block SHALL use a single clock.
REQ-003 Ports SHALL be, in order:
- clk  input  1  sole clock.
- rst  input  1  asynchronous active-high reset.
- reqN_valid  input  1  request pending, N in {0,1}.
- reqN_we  input  1  0 read, 1 write.
- reqN_addr  input  ADDR_W  entry index.
- reqN_wdata  input  DATA_W  write data.
- reqN_ready  output  1  request accepted this cycle.
- respN_valid  output  1  one-cycle response pulse.
- respN_rdata  output  DATA_W  read data; 0 for writes and errors.
- respN_err  output  1  out-of-range address or timeout.
- ram_enb  output  1  port-B enable to RAM.
- ram_web  output  1  port-B write select.
- ram_addrb  output  ADDR_W  port-B address.
- ram_dib  output  DATA_W  port-B write data.
- ram_dob  input  DATA_W  port-B read data.
- ram_dob_valid  input  1  port-B completion.
- busy  output  1  high in every state except IDLE.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-005 IDLE: if any reqN_valid, arbitrate, latch we/addr/wdata/owner, assert the winner's reqN_ready combinationally in that cycle, go to ISSUE; the loser's ready SHALL stay 0.
REQ-006 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last; after reset requester 0 has priority.
REQ-007 Latched addr >= DEPTH SHALL skip the RAM: IDLE -> RESP with err=1, ram_enb never asserted.
REQ-008 ISSUE SHALL drive ram_enb=1 for exactly one cycle with latched ram_web/ram_addrb/ram_dib, then go to WAIT.
REQ-009 ram_addrb, ram_web, ram_dib SHALL hold latched values from ISSUE through WAIT; ram_enb SHALL be 0 outside ISSUE.
REQ-010 WAIT: on ram_dob_valid=1 capture ram_dob (reads only) and go to RESP; TIMEOUT cycles in WAIT without it -> RESP with err=1.
REQ-011 RESP SHALL pulse owner's respN_valid for one cycle with rdata/err, then go to IDLE; other respN_valid stays 0.
REQ-012 Timing: acceptance in cycle T, ram_enb high in T+1, RAM completion seen in T+4, respN_valid high in T+5, next acceptance possible in T+6; out-of-range response in T+1.
REQ-013 ram_dob_valid outside WAIT SHALL be ignored.
REQ-014 Request inputs SHALL be sampled only in IDLE; changes while busy have no effect.
REQ-015 Timeout counter SHALL clear on WAIT entry and SHALL not wrap (saturate at TIMEOUT).

Reset
REQ-016 While rst=1: state IDLE, all outputs 0, last-grant set so requester 0 wins next tie, timeout counter 0.
REQ-017 Reset mid-operation SHALL discard the pending request with no response; ram_enb SHALL be 0 from reset assertion.

Verification
REQ-018 Read: req0 read addr 5, RAM model returns 4'hA -> ram_enb pulse T+1, resp0_valid at T+5, rdata=4'hA, err=0.
REQ-019 Write: req1 write addr 1069 data 4'h3 -> ram_web=1, ram_addrb=1069, ram_dib=3 held T+1..T+4, resp1_valid at T+5, rdata=0.
REQ-020 Contention: both valid continuously -> grants alternate 0,1,0,1 starting with 0, one response per 6 cycles.
REQ-021 Range: req0 addr 1070 -> ram_enb stays 0, resp0_valid at T+1, err=1.
REQ-022 Timeout: RAM model never asserts ram_dob_valid -> resp err=1 after 8 WAIT cycles, then IDLE.
REQ-023 Reset in WAIT: rst pulse -> no respN_valid, busy=0, next tie granted to requester 0.

Source files
------------

// File: rtl/ram_portb_arbiter.sv
// Two-requester round-robin arbiter sharing a single RAM port B.
// One transaction in flight at a time; each request gets exactly one response pulse.
module ram_portb_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 1070,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,
  output logic              ram_enb,
  output logic              ram_web,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic [DATA_W-1:0] ram_dib,
  input  logic [DATA_W-1:0] ram_dob,
  input  logic              ram_dob_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic              grant_vld;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;

  logic              owner_q;
  logic              last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  // Winner selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = req1_valid;
    end
    sel_we    = grant ? req1_we    : req0_we;
    sel_addr  = grant ? req1_addr  : req0_addr;
    sel_wdata = grant ? req1_wdata : req0_wdata;
    sel_oor   = ({1'b0, sel_addr} >= DEPTH_L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    ram_enb     = 1'b0;
    resp0_valid = 1'b0;
    resp0_rdata = '0;
    resp0_err   = 1'b0;
    resp1_valid = 1'b0;
    resp1_rdata = '0;
    resp1_err   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req0_ready = ~grant;
          req1_ready = grant;
          state_nxt  = sel_oor ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        ram_enb   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (ram_dob_valid || (cnt_q == TMO_LAST)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (owner_q) begin
          resp1_valid = 1'b1;
          resp1_rdata = rdata_q;
          resp1_err   = err_q;
        end else begin
          resp0_valid = 1'b1;
          resp0_rdata = rdata_q;
          resp0_err   = err_q;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction registers are cleared by reset too, so every output reads 0 while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner_q <= grant;
            last_q  <= grant;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
            err_q   <= sel_oor;
          end
        end
        ISSUE: begin
          cnt_q <= '0;
        end
        WAIT: begin
          if (ram_dob_valid) begin
            if (!we_q) begin
              rdata_q <= ram_dob;
            end
          end else if (cnt_q == TMO_LAST) begin
            err_q <= 1'b1;
          end
          if (cnt_q != TMO_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_web   = we_q;
  assign ram_addrb = addr_q;
  assign ram_dib   = wdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// Directed bench for ram_portb_arbiter: scoreboard queue filled by the driver,
// drained by a monitor that checks owner, data, error flag and response cycle.
module tb_ram_portb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req0_ready;
  logic [10:0] req0_addr;
  logic [3:0]  req0_wdata;
  logic        req1_valid, req1_we, req1_ready;
  logic [10:0] req1_addr;
  logic [3:0]  req1_wdata;
  logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [3:0]  resp0_rdata, resp1_rdata;
  logic        ram_enb, ram_web;
  logic [10:0] ram_addrb;
  logic [3:0]  ram_dib, ram_dob;
  logic        ram_dob_valid;
  logic        busy;

  logic        silent;
  logic        spurious;
  logic [2:0]  sh;
  logic [3:0]  rd_q;
  logic [3:0]  mem [0:2047];
  logic        init_done;
  int          cyc;
  int          enb_count;

  typedef struct {
    int       port;
    logic [3:0] rdata;
    logic     err;
    int       at;
  } exp_t;
  exp_t q[$];

  int checks;
  int errors;

  ram_portb_arbiter #(.ADDR_W(11), .DATA_W(4), .DEPTH(1070), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dib(ram_dib),
    .ram_dob(ram_dob), .ram_dob_valid(ram_dob_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: completion seen three cycles after the enable cycle.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 4'h0;
      mem[5] <= 4'hA;
      mem[7] <= 4'h6;
      init_done <= 1'b1;
    end else if (ram_enb) begin
      rd_q <= mem[ram_addrb];
      if (ram_web) mem[ram_addrb] <= ram_dib;
    end
    sh <= {sh[1:0], ram_enb & ~silent};
    if (ram_enb) enb_count <= enb_count + 1;
  end

  assign ram_dob_valid = sh[2] | spurious;
  assign ram_dob       = rd_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && (resp0_valid || resp1_valid)) begin
        chk("resp_onehot", int'(resp0_valid & resp1_valid), 0);
        if (q.size() == 0) begin
          chk("unexpected_resp", int'({resp1_valid, resp0_valid}), 0);
        end else begin
          e = q.pop_front();
          chk("resp_port", resp1_valid ? 1 : 0, e.port);
          chk("resp_rdata", int'(resp1_valid ? resp1_rdata : resp0_rdata), int'(e.rdata));
          chk("resp_err", int'(resp1_valid ? resp1_err : resp0_err), int'(e.err));
          chk("resp_cycle", cyc, e.at);
        end
      end
    end
  endtask

  task automatic do_req(input int port, input logic we, input logic [10:0] addr,
                        input logic [3:0] wdata, input logic [3:0] exp_rdata,
                        input logic exp_err, input int lat, input logic push);
    logic got;
    exp_t e;
    @(negedge clk);
    if (port == 1) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end
    #1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ((port == 1) ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("ready_seen", int'(got), 1);
    chk("loser_ready", int'((port == 1) ? req0_ready : req1_ready), 0);
    if (got && push) begin
      e.port = port; e.rdata = exp_rdata; e.err = exp_err; e.at = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (!busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    int ec, n, last_t, g;
    exp_t e;
    logic [1:0] exp_g [0:3];
    logic done;
    exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd0; exp_g[3] = 2'd1;
    checks = 0; errors = 0; cyc = 0; enb_count = 0; init_done = 1'b0;
    sh = 3'b000; rd_q = 4'h0;
    rst = 1'b1; silent = 1'b0; spurious = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", int'({busy, ram_enb, ram_web, resp0_valid, resp1_valid, resp0_err, resp1_err}), 0);
    chk("reset_bus", int'({ram_addrb, ram_dib, resp0_rdata, resp1_rdata}), 0);
    @(negedge clk);
    rst = 1'b0;
    fork monitor(); join_none

    // Read: enable pulse in T+1 only, response T+5.
    do_req(0, 1'b0, 11'd5, 4'h0, 4'hA, 1'b0, 5, 1'b1);
    chk("read_enb_t1", int'(ram_enb), 1);
    chk("read_addr_t1", int'(ram_addrb), 5);
    @(posedge clk); #1;
    chk("read_enb_t2", int'(ram_enb), 0);
    wait_idle("read_done");

    // Write: port-B signals held T+1..T+4.
    do_req(1, 1'b1, 11'd1069, 4'h3, 4'h0, 1'b0, 5, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("wr_web", int'(ram_web), 1);
      chk("wr_addr", int'(ram_addrb), 1069);
      chk("wr_dib", int'(ram_dib), 3);
      chk("wr_enb", int'(ram_enb), (k == 1) ? 1 : 0);
      @(posedge clk); #1;
    end
    wait_idle("write_done");
    do_req(1, 1'b0, 11'd1069, 4'h0, 4'h3, 1'b0, 5, 1'b1);
    wait_idle("readback_done");

    // Out of range: no RAM access, response T+1.
    ec = enb_count;
    do_req(0, 1'b0, 11'd1070, 4'h0, 4'h0, 1'b1, 1, 1'b1);
    wait_idle("range_done");
    chk("range_no_enb", enb_count, ec);

    // Completion strobe while idle must be ignored.
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("spurious_busy", int'(busy), 0);
    spurious = 1'b0;

    // Timeout: 8 WAIT cycles (T+2..T+9), response T+10.
    silent = 1'b1;
    do_req(0, 1'b0, 11'd5, 4'h0, 4'h0, 1'b1, 10, 1'b1);
    wait_idle("timeout_done");
    silent = 1'b0;

    // Reset while in WAIT after a req0 grant: no response, tie goes back to req0.
    do_req(0, 1'b0, 11'd5, 4'h0, 4'h0, 1'b0, 5, 1'b0);
    @(posedge clk); #1;
    chk("wait_busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_enb", int'(ram_enb), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_idle", int'(busy), 0);

    // Contention: both valid continuously, grants 0,1,0,1 six cycles apart.
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 11'd5;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 11'd7;
    n = 0; last_t = 0; done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("tie_onehot", int'(req0_ready & req1_ready), 0);
        g = req1_ready ? 1 : 0;
        chk("tie_grant", g, int'(exp_g[n]));
        if (n > 0) chk("tie_spacing", cyc - last_t, 6);
        e.port = g; e.rdata = g ? 4'h6 : 4'hA; e.err = 1'b0; e.at = cyc + 5;
        q.push_back(e);
        last_t = cyc;
        n++;
        if (n == 4) begin
          done = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    chk("tie_all_grants", int'(done), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle("tie_done");
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
